// File: rtl/mcu_pkg.sv
// Shared types and widths for the program-memory UART loader.
package mcu_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned ADDR_W  = 8;
  localparam logic [3:0]  HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_HI,
    WAIT_LO,
    DONE
  } asm_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx
  import mcu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          valid_n, ferr_n;

  // rx_prev is a third stage used only to detect the start-bit falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n   = START;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_sync) begin
            valid_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_out = shreg;

endmodule

// File: rtl/pmem_uart_loader.sv
// Loads a program over UART: byte pairs {A,hi nibble},{low byte} become
// 12-bit instructions written sequentially into program memory.
module pmem_uart_loader
  import mcu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PROG_DEPTH   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               load_en,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [INSTR_W-1:0] load_instr,
  output logic               load_we,
  output logic               load_done,
  output logic               frame_err,
  output logic               sync_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_DEPTH - 1);

  logic [7:0]         rx_byte;
  logic               rx_valid;

  asm_state_t         state, state_n;
  logic [3:0]         hi_nib, hi_nib_n;
  logic               load_en_d, load_en_rise;
  logic               inc_pend, inc_pend_n;
  logic               last_wr, last_wr_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [INSTR_W-1:0] instr_n;
  logic               we_n, done_n, serr_n;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  assign load_en_rise = load_en && !load_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_HI;
      hi_nib     <= '0;
      load_en_d  <= 1'b0;
      inc_pend   <= 1'b0;
      last_wr    <= 1'b0;
      load_addr  <= '0;
      load_instr <= '0;
      load_we    <= 1'b0;
      load_done  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      hi_nib     <= hi_nib_n;
      load_en_d  <= load_en;
      inc_pend   <= inc_pend_n;
      last_wr    <= last_wr_n;
      load_addr  <= addr_n;
      load_instr <= instr_n;
      load_we    <= we_n;
      load_done  <= done_n;
      sync_err   <= serr_n;
    end
  end

  // The address advances two edges after the write decision so it is stable
  // for the whole strobe; last_wr remembers whether that write was the final one.
  always_comb begin
    state_n    = state;
    hi_nib_n   = hi_nib;
    inc_pend_n = 1'b0;
    last_wr_n  = last_wr;
    addr_n     = load_addr;
    instr_n    = load_instr;
    we_n       = 1'b0;
    done_n     = load_done;
    serr_n     = 1'b0;

    if (load_we) begin
      if (last_wr) begin
        done_n = 1'b1;
      end else begin
        inc_pend_n = 1'b1;
      end
    end
    if (inc_pend) begin
      addr_n = load_addr + 1'b1;
    end

    if (load_en_rise) begin
      state_n    = WAIT_HI;
      addr_n     = '0;
      done_n     = 1'b0;
      inc_pend_n = 1'b0;
      last_wr_n  = 1'b0;
    end else if (!load_en) begin
      state_n = WAIT_HI;
    end else if (frame_err && state == WAIT_LO) begin
      state_n = WAIT_HI;
    end else if (rx_valid) begin
      case (state)
        WAIT_HI: begin
          if (rx_byte[7:4] == HDR_TAG) begin
            hi_nib_n = rx_byte[3:0];
            state_n  = WAIT_LO;
          end else begin
            serr_n = 1'b1;
          end
        end
        WAIT_LO: begin
          instr_n   = INSTR_W'({hi_nib, rx_byte});
          we_n      = 1'b1;
          last_wr_n = (load_addr == LAST);
          state_n   = (load_addr == LAST) ? DONE : WAIT_HI;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_uart_loader.sv
// Self-checking bench for pmem_uart_loader: byte-level table, hand sequences,
// and a randomized byte stream checked against a pair-framing model.
module tb_pmem_uart_loader;

  localparam int CPB   = 16;
  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr;
  logic [11:0] load_instr;
  logic        load_we, load_done, frame_err, sync_err;

  pmem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .PROG_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_instr(load_instr),
    .load_we   (load_we),
    .load_done (load_done),
    .frame_err (frame_err),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] instr;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    bit          stop_ok;
    int          we;
    int          serr;
    int          ferr;
    logic [11:0] instr;
  } vec_t;

  int  tests = 0, fails = 0;
  int  cyc = 0;
  wr_t wq[$];
  int  we_cnt = 0, serr_cnt = 0, ferr_cnt = 0, we_cyc = 0, done_cyc = -1;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_we === 1'b1) begin
      wq.push_back('{load_addr, load_instr});
      we_cnt++;
      we_cyc = cyc;
    end
    if (sync_err === 1'b1) serr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (load_done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = load_done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_ok;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic restart_load();
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
  endtask

  vec_t vt[7];
  int   exp_addr;
  int   w0, s0, f0;
  bit   have_hi, mdone;
  logic [3:0] mhi;
  int   nw, eserr, eferr;
  wr_t  expq[$];
  logic [7:0] rb;
  bit   rok;

  initial begin
    // byte, stop ok, writes, sync errs, frame errs, instr of the write
    vt[0] = '{8'h53, 1'b1, 0, 1, 0, 12'h000};
    vt[1] = '{8'hA7, 1'b1, 0, 0, 0, 12'h000};
    vt[2] = '{8'h3C, 1'b1, 1, 0, 0, 12'h73C};
    vt[3] = '{8'hA1, 1'b1, 0, 0, 0, 12'h000};
    vt[4] = '{8'h99, 1'b0, 0, 0, 1, 12'h000};
    vt[5] = '{8'hA2, 1'b1, 0, 0, 0, 12'h000};
    vt[6] = '{8'h55, 1'b1, 1, 0, 0, 12'h255};

    repeat (3) tick();
    chk("reset_outputs", {8'h0, load_addr, load_instr, load_we, load_done, frame_err, sync_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // short low pulse on rx must be rejected as a glitch
    restart_load();
    w0 = we_cnt; s0 = serr_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk("glitch_events", we_cnt - w0 + serr_cnt - s0 + ferr_cnt - f0, 0);

    exp_addr = 0;
    for (int i = 0; i < 7; i++) begin
      w0 = we_cnt; s0 = serr_cnt; f0 = ferr_cnt;
      send_byte(vt[i].b, vt[i].stop_ok);
      chk($sformatf("vec%0d_we", i), we_cnt - w0, vt[i].we);
      chk($sformatf("vec%0d_serr", i), serr_cnt - s0, vt[i].serr);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vt[i].ferr);
      if (vt[i].we == 1 && wq.size() > 0) begin
        chk($sformatf("vec%0d_addr", i), wq[wq.size()-1].addr, exp_addr);
        chk($sformatf("vec%0d_instr", i), wq[wq.size()-1].instr, vt[i].instr);
        exp_addr++;
      end
    end

    // load window closed: pairs are ignored
    load_en = 1'b0;
    tick();
    w0 = we_cnt; s0 = serr_cnt;
    send_byte(8'hA1, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'hA4, 1'b1); send_byte(8'h56, 1'b1);
    chk("closed_we", we_cnt - w0, 0);
    chk("closed_serr", serr_cnt - s0, 0);

    // full program of DEPTH instructions
    restart_load();
    done_cyc = -1;
    for (int i = 0; i < DEPTH; i++) begin
      w0 = we_cnt;
      if (i == DEPTH - 1) chk("done_before_last", load_done, 0);
      send_byte(8'hA1, 1'b1);
      send_byte(8'(i), 1'b1);
      chk($sformatf("prog%0d_we", i), we_cnt - w0, 1);
      if (wq.size() > 0) begin
        chk($sformatf("prog%0d_addr", i), wq[wq.size()-1].addr, i);
        chk($sformatf("prog%0d_instr", i), wq[wq.size()-1].instr, 12'h100 + i);
      end
    end
    chk("done_level", load_done, 1);
    chk("done_latency", done_cyc, we_cyc + 1);

    w0 = we_cnt; s0 = serr_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'hAA, 1'b1);
    send_byte(8'hA6, 1'b1); send_byte(8'hBB, 1'b1);
    chk("after_done_we", we_cnt - w0, 0);
    chk("after_done_errs", serr_cnt - s0 + ferr_cnt - f0, 0);
    chk("after_done_addr", load_addr, DEPTH - 1);
    chk("after_done_level", load_done, 1);

    // asynchronous reset in the middle of a byte
    restart_load();
    for (int i = 1; i <= 3; i++) begin
      send_byte(8'hA1, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    chk("pre_reset_addr", load_addr, 3);
    rx = 1'b0;
    repeat (40) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {8'h0, load_addr, load_instr, load_we, load_done, frame_err, sync_err}, 32'h0);
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    restart_load();
    w0 = we_cnt;
    send_byte(8'hA7, 1'b1);
    send_byte(8'h77, 1'b1);
    chk("post_reset_we", we_cnt - w0, 1);
    if (wq.size() > 0) begin
      chk("post_reset_addr", wq[wq.size()-1].addr, 0);
      chk("post_reset_instr", wq[wq.size()-1].instr, 12'h777);
    end

    // randomized byte stream against a pair-framing model
    restart_load();
    wq.delete();
    w0 = we_cnt; s0 = serr_cnt; f0 = ferr_cnt;
    have_hi = 1'b0; mdone = 1'b0; mhi = '0; nw = 0; eserr = 0; eferr = 0;
    expq.delete();
    for (int k = 0; k < 48; k++) begin
      rok = ($urandom_range(0, 9) != 0);
      if (!have_hi && $urandom_range(0, 6) != 0) rb = {4'hA, 4'($urandom)};
      else rb = 8'($urandom);
      if (!rok) begin
        eferr++;
        if (!mdone) have_hi = 1'b0;
      end else if (mdone) begin
      end else if (!have_hi) begin
        if (rb[7:4] == 4'hA) begin
          have_hi = 1'b1;
          mhi = rb[3:0];
        end else begin
          eserr++;
        end
      end else begin
        expq.push_back('{8'(nw), {mhi, rb}});
        nw++;
        have_hi = 1'b0;
        if (nw == DEPTH) mdone = 1'b1;
      end
      send_byte(rb, rok);
    end
    chk("rand_we_count", we_cnt - w0, expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++) begin
      chk($sformatf("rand%0d_addr", i), wq[i].addr, expq[i].addr);
      chk($sformatf("rand%0d_instr", i), wq[i].instr, expq[i].instr);
    end
    chk("rand_serr", serr_cnt - s0, eserr);
    chk("rand_ferr", ferr_cnt - f0, eferr);
    chk("rand_done", load_done, mdone);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
